// File: rtl/fp_mul_pipe_if.sv
// Operand/result bundle for fp_mul_pipe: pipeline advance, operand pair in, product and flags out.
// The master side drives operands; the slave side is the multiplier.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int DATA_WIDTH = 1 + EXP_W + MAN_W;

    logic                  en;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] result;
    logic [3:0]            flags;

    modport master (
        output en, in_valid, a, b,
        input  out_valid, result, flags
    );

    modport slave (
        input  en, in_valid, a, b,
        output out_valid, result, flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754-style multiplier (FTZ, canonical qNaN, flags {invalid, overflow, underflow, inexact}).
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise the product is truncated toward zero.
module fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    fp_mul_pipe_if.slave  bus
);
    localparam int DATA_WIDTH = 1 + EXP_W + MAN_W;
    localparam int BIAS       = (1 << (EXP_W - 1)) - 1;
    localparam int PW         = 2 * (MAN_W + 1);
    localparam int XW         = EXP_W + 2;

    localparam logic [EXP_W-1:0]         EXP_ONES = '1;
    localparam logic signed [XW-1:0]     BIAS_X   = XW'(BIAS);
    localparam logic signed [XW-1:0]     EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic [DATA_WIDTH-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // ---------------- S1: classify + mantissa product ----------------
    logic                  w_sign_a, w_sign_b;
    logic [EXP_W-1:0]      w_exp_a, w_exp_b;
    logic [MAN_W-1:0]      w_frac_a, w_frac_b;
    logic                  w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic signed [XW-1:0]  w_exp_sum;
    logic [PW-1:0]         w_prod;

    assign w_sign_a = bus.a[DATA_WIDTH-1];
    assign w_sign_b = bus.b[DATA_WIDTH-1];
    assign w_exp_a  = bus.a[DATA_WIDTH-2:MAN_W];
    assign w_exp_b  = bus.b[DATA_WIDTH-2:MAN_W];
    assign w_frac_a = bus.a[MAN_W-1:0];
    assign w_frac_b = bus.b[MAN_W-1:0];

    // Subnormals have exp=0 and are flushed to zero here.
    assign w_zero_a = (w_exp_a == '0);
    assign w_zero_b = (w_exp_b == '0);
    assign w_inf_a  = (w_exp_a == EXP_ONES) && (w_frac_a == '0);
    assign w_inf_b  = (w_exp_b == EXP_ONES) && (w_frac_b == '0);
    assign w_nan_a  = (w_exp_a == EXP_ONES) && (w_frac_a != '0);
    assign w_nan_b  = (w_exp_b == EXP_ONES) && (w_frac_b != '0);

    assign w_exp_sum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - BIAS_X;
    assign w_prod    = PW'({1'b1, w_frac_a}) * PW'({1'b1, w_frac_b});

    logic                  r_s1_valid;
    logic                  r_s1_sign;
    logic                  r_s1_nan, r_s1_inv, r_s1_inf, r_s1_zero;
    logic signed [XW-1:0]  r_s1_exp;
    logic [PW-1:0]         r_s1_prod;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_prod  <= '0;
        end else if (bus.en) begin
            r_s1_valid <= bus.in_valid;
            r_s1_sign  <= w_sign_a ^ w_sign_b;
            r_s1_nan   <= w_nan_a | w_nan_b;
            r_s1_inv   <= (w_inf_a & w_zero_b) | (w_inf_b & w_zero_a);
            r_s1_inf   <= w_inf_a | w_inf_b;
            r_s1_zero  <= w_zero_a | w_zero_b;
            r_s1_exp   <= w_exp_sum;
            r_s1_prod  <= w_prod;
        end
    end

    // ---------------- S2: normalise + round ----------------
    logic                  w_norm;
    logic [MAN_W-1:0]      w_frac_pre;
    logic                  w_guard, w_sticky;
    logic signed [XW-1:0]  w_exp_norm;
    logic [MAN_W-1:0]      w_frac_rnd;
    logic signed [XW-1:0]  w_exp_rnd;

    // Product lies in [1,4); a set MSB means the binary point moves one place left.
    assign w_norm     = r_s1_prod[PW-1];
    assign w_frac_pre = w_norm ? r_s1_prod[PW-2 -: MAN_W] : r_s1_prod[PW-3 -: MAN_W];
    assign w_guard    = w_norm ? r_s1_prod[MAN_W] : r_s1_prod[MAN_W-1];
    assign w_sticky   = w_norm ? (|r_s1_prod[MAN_W-1:0]) : (|r_s1_prod[MAN_W-2:0]);
    assign w_exp_norm = r_s1_exp + XW'(w_norm);

`ifdef FP_MUL_RNE_EN
    logic                  w_round_up;
    logic [MAN_W:0]        w_frac_sum;

    assign w_round_up = w_guard & (w_sticky | w_frac_pre[0]);
    assign w_frac_sum = {1'b0, w_frac_pre} + (MAN_W+1)'(w_round_up);
    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign w_frac_rnd = w_frac_sum[MAN_W-1:0];
    assign w_exp_rnd  = w_exp_norm + XW'(w_frac_sum[MAN_W]);
`else
    assign w_frac_rnd = w_frac_pre;
    assign w_exp_rnd  = w_exp_norm;
`endif

    logic                  r_s2_valid;
    logic                  r_s2_sign;
    logic                  r_s2_nan, r_s2_inv, r_s2_inf, r_s2_zero;
    logic signed [XW-1:0]  r_s2_exp;
    logic [MAN_W-1:0]      r_s2_frac;
    logic                  r_s2_inexact;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_nan     <= 1'b0;
            r_s2_inv     <= 1'b0;
            r_s2_inf     <= 1'b0;
            r_s2_zero    <= 1'b0;
            r_s2_exp     <= '0;
            r_s2_frac    <= '0;
            r_s2_inexact <= 1'b0;
        end else if (bus.en) begin
            r_s2_valid   <= r_s1_valid;
            r_s2_sign    <= r_s1_sign;
            r_s2_nan     <= r_s1_nan;
            r_s2_inv     <= r_s1_inv;
            r_s2_inf     <= r_s1_inf;
            r_s2_zero    <= r_s1_zero;
            r_s2_exp     <= w_exp_rnd;
            r_s2_frac    <= w_frac_rnd;
            r_s2_inexact <= w_guard | w_sticky;
        end
    end

    // ---------------- S3: special-case select + pack ----------------
    logic                  w_ovf, w_udf;
    logic [DATA_WIDTH-1:0] w_result;
    logic [3:0]            w_flags;

    assign w_ovf = (r_s2_exp >= EXP_MAX);
    assign w_udf = r_s2_exp[XW-1] | (r_s2_exp == '0);

    always_comb begin
        w_result = {r_s2_sign, r_s2_exp[EXP_W-1:0], r_s2_frac};
        w_flags  = {3'b000, r_s2_inexact};
        if (r_s2_nan) begin
            w_result = QNAN;
            w_flags  = 4'b0000;
        end else if (r_s2_inv) begin
            w_result = QNAN;
            w_flags  = 4'b1000;
        end else if (r_s2_inf) begin
            w_result = {r_s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_flags  = 4'b0000;
        end else if (r_s2_zero) begin
            w_result = {r_s2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flags  = 4'b0000;
        end else if (w_ovf) begin
            w_result = {r_s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_flags  = 4'b0101;
        end else if (w_udf) begin
            w_result = {r_s2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flags  = 4'b0011;
        end
    end

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic [3:0]            r_flags;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (bus.en) begin
            r_out_valid <= r_s2_valid;
            r_result    <= w_result;
            r_flags     <= w_flags;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
endmodule
